// File: rtl/instr_prefetch_queue_pkg.sv
// prefetch_pkg: shared definitions for the instruction prefetch path.
//   OPCODE_W_DEF / ADDR_W_DEF : default opcode and address field widths.
//   instruction_t             : default-width {opcode, address} record used by
//                               neighbouring fetch/decode blocks.
package prefetch_pkg;

    localparam int OPCODE_W_DEF = 16;
    localparam int ADDR_W_DEF   = 64;

    typedef struct packed {
        logic [15:0] opcode;
        logic [63:0] address;
    } instruction_t;

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// instr_prefetch_queue_if: fetch-side and decode-side valid/ready handshakes
// of the instruction prefetch queue.
//   in_valid/in_ready/in_opcode/in_addr     : fetch unit -> queue
//   out_valid/out_ready/out_opcode/out_addr : queue -> decode
//   modport master : the environment (fetch producer + decode consumer)
//   modport slave  : the queue itself
interface instr_prefetch_queue_if
    import prefetch_pkg::*;
#(
    parameter int OPCODE_W = OPCODE_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
);

    logic                in_valid;
    logic                in_ready;
    logic [OPCODE_W-1:0] in_opcode;
    logic [ADDR_W-1:0]   in_addr;
    logic                out_valid;
    logic                out_ready;
    logic [OPCODE_W-1:0] out_opcode;
    logic [ADDR_W-1:0]   out_addr;

    modport master (
        output in_valid, in_opcode, in_addr, out_ready,
        input  in_ready, out_valid, out_opcode, out_addr
    );

    modport slave (
        input  in_valid, in_opcode, in_addr, out_ready,
        output in_ready, out_valid, out_opcode, out_addr
    );

endinterface

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: DEPTH-entry FIFO of {opcode, addr} instruction words
// between fetch and decode.
//   clk     : single clock, rising edge
//   rst_n   : asynchronous active-low reset (clears pointers, count, storage)
//   flush_i : synchronous discard of all entries (branch redirect)
//   count   : number of valid entries, 0..DEPTH
//   bus     : fetch (in_*) and decode (out_*) handshakes, slave side
// The head is only visible the cycle after it was written (no fall-through),
// and in_ready depends only on state, so a pop never frees a slot for a push
// in the same cycle.
module instr_prefetch_queue
    import prefetch_pkg::*;
#(
    parameter int OPCODE_W = OPCODE_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DEPTH    = 4,
    localparam int CNT_W   = $clog2(DEPTH) + 1
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    output logic [CNT_W-1:0]       count,
    instr_prefetch_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [ADDR_W-1:0]   addr;
    } entry_t;

    entry_t             mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               in_ready_s;
    logic               out_valid_s;
    logic               push_s;
    logic               pop_s;
    entry_t             in_entry_s;

    assign in_ready_s  = (cnt_r != CNT_FULL);
    assign out_valid_s = (cnt_r != {CNT_W{1'b0}});
    assign push_s      = bus.in_valid  & in_ready_s;
    assign pop_s       = bus.out_valid & bus.out_ready;
    assign in_entry_s  = '{opcode: bus.in_opcode, addr: bus.in_addr};

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign count         = cnt_r;

    // Occupancy update: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (push_s && !pop_s) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Pointer, count and storage state; flush overrides any handshake in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            mem_r    <= '{default: '0};
        end else if (flush_i) begin
            // Entry contents are deliberately left intact; only the bookkeeping resets.
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= in_entry_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            cnt_r <= cnt_nxt_s;
        end
    end

    // Head presentation: zeroed whenever the queue is empty so decode never sees stale data.
    always_comb begin
        bus.out_opcode = {OPCODE_W{1'b0}};
        bus.out_addr   = {ADDR_W{1'b0}};
        if (out_valid_s) begin
            bus.out_opcode = mem_r[rd_ptr_r].opcode;
            bus.out_addr   = mem_r[rd_ptr_r].addr;
        end else begin
            bus.out_opcode = {OPCODE_W{1'b0}};
            bus.out_addr   = {ADDR_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: directed self-checking bench for instr_prefetch_queue
// (DEPTH = 4, OPCODE_W = 16, ADDR_W = 64).
module tb_instr_prefetch_queue;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       flush_i = 1'b0;
    logic [2:0] count;
    int         total   = 0;
    int         bad     = 0;

    instr_prefetch_queue_if #(.OPCODE_W(16), .ADDR_W(64)) bus ();

    instr_prefetch_queue #(.OPCODE_W(16), .ADDR_W(64), .DEPTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .count   (count),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] op, input logic [63:0] addr);
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_addr   = addr;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_opcode = 16'h0;
        bus.in_addr   = 64'h0;
        bus.out_ready = 1'b0;

        // Reset held low: idle values before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", {63'h0, bus.in_ready}, 64'h1);
        chk("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("rst_opcode", {48'h0, bus.out_opcode}, 64'h0);
        chk("rst_addr", bus.out_addr, 64'h0);
        chk("rst_count", {61'h0, count}, 64'h0);
        tick();
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Single word, then consume it.
        push(16'hface, 64'h1);
        chk("single_valid", {63'h0, bus.out_valid}, 64'h1);
        chk("single_opcode", {48'h0, bus.out_opcode}, 64'hface);
        chk("single_addr", bus.out_addr, 64'h1);
        chk("single_count", {61'h0, count}, 64'h1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("single_pop_count", {61'h0, count}, 64'h0);
        chk("single_pop_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("single_pop_opcode", {48'h0, bus.out_opcode}, 64'h0);
        chk("single_pop_addr", bus.out_addr, 64'h0);

        // Fill to DEPTH; a fifth offered word is ignored.
        for (int a = 1; a <= 4; a++) begin
            push(16'h1000 + 16'(a), 64'(a));
        end
        chk("full_count", {61'h0, count}, 64'h4);
        chk("full_in_ready", {63'h0, bus.in_ready}, 64'h0);
        chk("full_head", bus.out_addr, 64'h1);
        push(16'h1005, 64'h5);
        chk("full_ignore_count", {61'h0, count}, 64'h4);
        chk("full_ignore_head", bus.out_addr, 64'h1);

        // Pop two, push 5 and 6 across the pointer wrap, then drain.
        bus.out_ready = 1'b1;
        tick();
        chk("pop1_head", bus.out_addr, 64'h2);
        tick();
        bus.out_ready = 1'b0;
        chk("pop2_count", {61'h0, count}, 64'h2);
        push(16'h1005, 64'h5);
        push(16'h1006, 64'h6);
        chk("refill_count", {61'h0, count}, 64'h4);
        bus.out_ready = 1'b1;
        for (int e = 3; e <= 6; e++) begin
            chk("drain_addr", bus.out_addr, 64'(e));
            chk("drain_opcode", {48'h0, bus.out_opcode}, 64'h1000 + 64'(e));
            tick();
        end
        bus.out_ready = 1'b0;
        chk("drain_count", {61'h0, count}, 64'h0);
        chk("drain_valid", {63'h0, bus.out_valid}, 64'h0);

        // Streaming: one push and one pop per cycle with count held at 1.
        push(16'h2000, 64'h100);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_opcode = 16'h2001 + 16'(i);
            bus.in_addr   = 64'h101 + 64'(i);
            chk("stream_head", bus.out_addr, 64'h100 + 64'(i));
            chk("stream_count", {61'h0, count}, 64'h1);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("stream_last", bus.out_addr, 64'h114);
        chk("stream_last_op", {48'h0, bus.out_opcode}, 64'h2014);
        tick();
        bus.out_ready = 1'b0;
        chk("stream_end_count", {61'h0, count}, 64'h0);

        // Flush colliding with a push and a pop.
        push(16'h3001, 64'h10);
        push(16'h3002, 64'h20);
        push(16'h3003, 64'h30);
        chk("pre_flush_count", {61'h0, count}, 64'h3);
        flush_i       = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_addr   = 64'h99;
        bus.out_ready = 1'b1;
        tick();
        flush_i       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush_count", {61'h0, count}, 64'h0);
        chk("flush_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("flush_addr", bus.out_addr, 64'h0);
        push(16'h3004, 64'h40);
        chk("post_flush_head", bus.out_addr, 64'h40);
        chk("post_flush_count", {61'h0, count}, 64'h1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Asynchronous reset between edges with two words queued.
        push(16'h4001, 64'h50);
        push(16'h4002, 64'h60);
        chk("pre_rst_count", {61'h0, count}, 64'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_in_ready", {63'h0, bus.in_ready}, 64'h1);
        chk("async_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("async_opcode", {48'h0, bus.out_opcode}, 64'h0);
        chk("async_addr", bus.out_addr, 64'h0);
        chk("async_count", {61'h0, count}, 64'h0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("post_rst_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("post_rst_count", {61'h0, count}, 64'h0);
        push(16'h5001, 64'h70);
        chk("post_rst_head", bus.out_addr, 64'h70);
        chk("post_rst_opcode", {48'h0, bus.out_opcode}, 64'h5001);
        chk("post_rst_count1", {61'h0, count}, 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
